// File: rtl/mole_game_core_if.sv
// Bundle of game-side signals between the button/tick sources and the Whac-A-Mole core.
// The master side drives enable, tick and buttons; the core (slave) drives display, score and pulses.
interface mole_game_core_if #(
    parameter int N_HOLES = 8,
    parameter int SCORE_W = 10
);
    logic               en;
    logic               tick;
    logic [N_HOLES-1:0] button;
    logic [N_HOLES-1:0] leds;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic               hit;
    logic               miss;
    logic               game_over;

    modport master (
        output en, tick, button,
        input  leds, score, lives, hit, miss, game_over
    );

    modport slave (
        input  en, tick, button,
        output leds, score, lives, hit, miss, game_over
    );
endinterface

// File: rtl/mole_game_core.sv
// Whac-A-Mole engine: random mole placement, per-mole lifetime, hit/miss judging,
// saturating score, lives and a difficulty ramp, all in one registered FSM.
module mole_game_core #(
    parameter int          N_HOLES    = 8,
    parameter int          SCORE_W    = 10,
    parameter int          SCORE_MAX  = 999,
    parameter int          LIVES      = 3,
    parameter int          MOLE_TICKS = 8,
    parameter int          MIN_TICKS  = 2,
    parameter int          GAP_TICKS  = 2,
    parameter int          LEVEL_STEP = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic             clk,
    input logic             rst_n,
    mole_game_core_if.slave bus
);
    localparam int          IDX_W     = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int          TW        = 8;
    localparam int          CW        = 8;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;

    state_t             state_reg;
    logic [15:0]        lfsr_reg;
    logic [N_HOLES-1:0] button_q_reg;
    logic [N_HOLES-1:0] leds_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [2:0]         lives_reg;
    logic               hit_reg;
    logic               miss_reg;
    logic               over_reg;
    logic [TW-1:0]      mole_time_reg;
    logic [TW-1:0]      timer_reg;
    logic [CW-1:0]      hit_cnt_reg;
    logic [IDX_W-1:0]   prev_reg;

    logic [N_HOLES-1:0] press;
    logic [IDX_W-1:0]   raw_idx;
    logic [IDX_W-1:0]   spawn_idx;
    logic               mole_hit;
    logic               lose_life;

    assign press     = bus.button & ~button_q_reg;
    assign mole_hit  = |(press & leds_reg);
    // A hit always wins over a simultaneous wrong press or expiring tick.
    assign lose_life = !mole_hit && ((|(press & ~leds_reg)) || (bus.tick && timer_reg == TW'(1)));

    always_comb begin
        raw_idx   = IDX_W'(32'(lfsr_reg[IDX_W-1:0]) % N_HOLES);
        spawn_idx = raw_idx;
        if (raw_idx == prev_reg) begin
            spawn_idx = (32'(raw_idx) == N_HOLES - 1) ? '0 : raw_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lfsr_reg      <= LFSR_SEED;
            button_q_reg  <= '0;
            leds_reg      <= '0;
            score_reg     <= '0;
            lives_reg     <= 3'(LIVES);
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
            over_reg      <= 1'b0;
            mole_time_reg <= TW'(MOLE_TICKS);
            timer_reg     <= '0;
            hit_cnt_reg   <= '0;
            prev_reg      <= '0;
        end else begin
            // The LFSR free-runs so mole placement depends on player timing.
            lfsr_reg     <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
            button_q_reg <= bus.button;
            hit_reg      <= 1'b0;
            miss_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    leds_reg <= '0;
                    over_reg <= 1'b0;
                    if (bus.en) begin
                        score_reg     <= '0;
                        lives_reg     <= 3'(LIVES);
                        mole_time_reg <= TW'(MOLE_TICKS);
                        hit_cnt_reg   <= '0;
                        state_reg     <= SPAWN;
                    end
                end
                SPAWN: begin
                    if (!bus.en) begin
                        leds_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        leds_reg  <= N_HOLES'(1) << spawn_idx;
                        prev_reg  <= spawn_idx;
                        timer_reg <= mole_time_reg;
                        state_reg <= UP;
                    end
                end
                UP: begin
                    if (!bus.en) begin
                        leds_reg  <= '0;
                        state_reg <= IDLE;
                    end else if (mole_hit) begin
                        hit_reg   <= 1'b1;
                        leds_reg  <= '0;
                        timer_reg <= TW'(GAP_TICKS);
                        state_reg <= GAP;
                        if (score_reg < SCORE_W'(SCORE_MAX)) begin
                            score_reg <= score_reg + SCORE_W'(1);
                        end
                        if (hit_cnt_reg == CW'(LEVEL_STEP - 1)) begin
                            hit_cnt_reg <= '0;
                            if (mole_time_reg > TW'(MIN_TICKS)) begin
                                mole_time_reg <= mole_time_reg - TW'(1);
                            end
                        end else begin
                            hit_cnt_reg <= hit_cnt_reg + CW'(1);
                        end
                    end else if (lose_life) begin
                        miss_reg  <= 1'b1;
                        lives_reg <= lives_reg - 3'd1;
                        if (lives_reg == 3'd1) begin
                            leds_reg  <= '1;
                            over_reg  <= 1'b1;
                            state_reg <= OVER;
                        end else begin
                            leds_reg  <= '0;
                            timer_reg <= TW'(GAP_TICKS);
                            state_reg <= GAP;
                        end
                    end else if (bus.tick) begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                GAP: begin
                    leds_reg <= '0;
                    if (!bus.en) begin
                        state_reg <= IDLE;
                    end else if (bus.tick) begin
                        if (timer_reg <= TW'(1)) begin
                            state_reg <= SPAWN;
                        end else begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end
                end
                OVER: begin
                    leds_reg <= '1;
                    over_reg <= 1'b1;
                    if (!bus.en) begin
                        leds_reg  <= '0;
                        over_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.leds      = leds_reg;
    assign bus.score     = score_reg;
    assign bus.lives     = lives_reg;
    assign bus.hit       = hit_reg;
    assign bus.miss      = miss_reg;
    assign bus.game_over = over_reg;
endmodule

// File: tb/tb_mole_game_core.sv
// Scenario bench for mole_game_core: hits, timeouts, lives, difficulty ramp, score
// saturation and a long run of spawns checked against a reference LFSR hole model.
module tb_mole_game_core;
    localparam int          N     = 8;
    localparam int          SW    = 10;
    localparam int          SMAX  = 40;
    localparam int          LIV   = 3;
    localparam int          MOLE  = 8;
    localparam int          MINT  = 2;
    localparam int          GAPT  = 2;
    localparam int          STEP  = 5;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          IDX_W = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mole_game_core_if #(.N_HOLES(N), .SCORE_W(SW)) bus ();

    mole_game_core #(
        .N_HOLES(N), .SCORE_W(SW), .SCORE_MAX(SMAX), .LIVES(LIV), .MOLE_TICKS(MOLE),
        .MIN_TICKS(MINT), .GAP_TICKS(GAPT), .LEVEL_STEP(STEP), .LFSR_SEED(SEED)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference Galois LFSR, reset alongside the DUT.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct {
        logic [SW-1:0] score;
        logic [2:0]    lives;
    } exp_t;
    exp_t sb[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            spawns   = 0;
    int            m_prev   = 0;
    logic [N-1:0]  last_mole = '0;
    logic [SW-1:0] exp_score = '0;
    logic [2:0]    exp_lives = 3'(LIV);

    task automatic wait_mole(output int iters);
        logic [15:0] lfsr_prev;
        logic [N-1:0] one, exp_leds;
        int idx;
        bit found;
        one = 1; found = 0; iters = -1; lfsr_prev = m_lfsr;
        for (int i = 1; i <= 100 && !found; i++) begin
            @(negedge clk);
            if (bus.leds != '0 && !bus.game_over) begin
                found = 1; iters = i; bus.tick = 1'b0;
            end else begin
                lfsr_prev = m_lfsr; bus.tick = 1'b1;
            end
        end
        bus.tick = 1'b0;
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mole_appear: no mole within 100 cycles, leds=%h required nonzero", bus.leds);
        end else begin
            idx = int'(lfsr_prev[IDX_W-1:0]) % N;
            if (idx == m_prev) idx = (idx + 1) % N;
            m_prev = idx;
            exp_leds = one << idx;
            n_checks++;
            if (bus.leds !== exp_leds) begin
                n_fail++;
                $display("FAIL spawn_hole: leds=%h required %h", bus.leds, exp_leds);
            end
            n_checks++;
            if (bus.leds === last_mole) begin
                n_fail++;
                $display("FAIL back_to_back: leds=%h required differ from %h", bus.leds, last_mole);
            end
            last_mole = bus.leds;
            spawns++;
            $display("spawn %0d: leds=%h after %0d cycles", spawns, bus.leds, iters);
        end
    endtask

    task automatic press_hit(input logic [N-1:0] extra, input logic with_tick);
        exp_t e;
        if (exp_score < SW'(SMAX)) exp_score = exp_score + 1'b1;
        sb.push_back('{exp_score, exp_lives});
        bus.button = bus.leds | extra;
        bus.tick   = with_tick;
        @(negedge clk);
        bus.button = '0;
        bus.tick   = 1'b0;
        e = sb.pop_front();
        $display("hit: hit=%b miss=%b score=%0d lives=%0d leds=%h", bus.hit, bus.miss, bus.score, bus.lives, bus.leds);
        n_checks++;
        if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: hit=%b required 1", bus.hit); end
        n_checks++;
        if (bus.miss !== 1'b0) begin n_fail++; $display("FAIL hit_no_miss: miss=%b required 0", bus.miss); end
        n_checks++;
        if (bus.leds !== '0) begin n_fail++; $display("FAIL hit_leds: leds=%h required 0", bus.leds); end
        n_checks++;
        if (bus.score !== e.score) begin n_fail++; $display("FAIL hit_score: score=%0d required %0d", bus.score, e.score); end
        n_checks++;
        if (bus.lives !== e.lives) begin n_fail++; $display("FAIL hit_lives: lives=%0d required %0d", bus.lives, e.lives); end
        @(negedge clk);
        n_checks++;
        if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL hit_width: hit=%b required 0", bus.hit); end
    endtask

    task automatic time_out(output int nticks);
        exp_t e;
        bit seen;
        exp_lives = exp_lives - 3'd1;
        sb.push_back('{exp_score, exp_lives});
        nticks = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.tick = 1'b1;
            @(negedge clk);
            nticks++;
            if (bus.miss === 1'b1) seen = 1;
        end
        bus.tick = 1'b0;
        e = sb.pop_front();
        $display("timeout: ticks=%0d miss=%b lives=%0d over=%b leds=%h", nticks, bus.miss, bus.lives, bus.game_over, bus.leds);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL timeout_miss: miss=%b required 1 within 40 ticks", bus.miss); end
        n_checks++;
        if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL timeout_no_hit: hit=%b required 0", bus.hit); end
        n_checks++;
        if (bus.lives !== e.lives) begin n_fail++; $display("FAIL timeout_lives: lives=%0d required %0d", bus.lives, e.lives); end
        n_checks++;
        if (bus.score !== e.score) begin n_fail++; $display("FAIL timeout_score: score=%0d required %0d", bus.score, e.score); end
        n_checks++;
        if (bus.game_over !== (e.lives == 3'd0)) begin
            n_fail++; $display("FAIL timeout_over: game_over=%b required %b", bus.game_over, e.lives == 3'd0);
        end
        n_checks++;
        if (bus.leds !== ((e.lives == 3'd0) ? {N{1'b1}} : {N{1'b0}})) begin
            n_fail++; $display("FAIL timeout_leds: leds=%h lives=%0d", bus.leds, e.lives);
        end
        @(negedge clk);
        n_checks++;
        if (bus.miss !== 1'b0) begin n_fail++; $display("FAIL miss_width: miss=%b required 0", bus.miss); end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.tick = 1'b0; bus.button = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        $display("reset: leds=%h score=%0d lives=%0d hit=%b miss=%b over=%b",
                 bus.leds, bus.score, bus.lives, bus.hit, bus.miss, bus.game_over);
        n_checks++;
        if (bus.leds !== '0) begin n_fail++; $display("FAIL reset_leds: leds=%h required 0", bus.leds); end
        n_checks++;
        if (bus.score !== '0) begin n_fail++; $display("FAIL reset_score: score=%0d required 0", bus.score); end
        n_checks++;
        if (bus.lives !== 3'(LIV)) begin n_fail++; $display("FAIL reset_lives: lives=%0d required %0d", bus.lives, LIV); end
        n_checks++;
        if ({bus.hit, bus.miss, bus.game_over} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: hit/miss/over=%b required 000", {bus.hit, bus.miss, bus.game_over});
        end
        rst_n = 1'b1;
        m_prev = 0; last_mole = '0; exp_score = '0; exp_lives = 3'(LIV);
    endtask

    task automatic test_start();
        int it;
        @(negedge clk);
        bus.en = 1'b1;
        wait_mole(it);
        n_checks++;
        if (it !== 2) begin n_fail++; $display("FAIL start_latency: %0d cycles required 2", it); end
        n_checks++;
        if (bus.score !== '0 || bus.lives !== 3'(LIV)) begin
            n_fail++; $display("FAIL start_state: score=%0d lives=%0d required 0/%0d", bus.score, bus.lives, LIV);
        end
    endtask

    task automatic test_hit();
        int it;
        press_hit('0, 1'b0);
        wait_mole(it);
        n_checks++;
        if (it !== GAPT + 2) begin n_fail++; $display("FAIL gap_length: %0d cycles required %0d", it, GAPT + 2); end
    endtask

    task automatic test_timeout_to_over();
        int nt, it;
        for (int k = 0; k < LIV; k++) begin
            time_out(nt);
            n_checks++;
            if (nt !== MOLE) begin n_fail++; $display("FAIL mole_lifetime: %0d ticks required %0d", nt, MOLE); end
            if (exp_lives != 3'd0) wait_mole(it);
        end
        repeat (3) begin
            bus.tick = 1'b1;
            @(negedge clk);
        end
        bus.tick = 1'b0;
        n_checks++;
        if (bus.game_over !== 1'b1 || bus.leds !== {N{1'b1}} || bus.lives !== 3'd0 || bus.score !== exp_score) begin
            n_fail++;
            $display("FAIL over_frozen: over=%b leds=%h lives=%0d score=%0d required 1/ff/0/%0d",
                     bus.game_over, bus.leds, bus.lives, bus.score, exp_score);
        end
        bus.en = 1'b0;
        @(negedge clk);
        $display("over exit: leds=%h over=%b", bus.leds, bus.game_over);
        n_checks++;
        if (bus.leds !== '0 || bus.game_over !== 1'b0) begin
            n_fail++; $display("FAIL over_exit: leds=%h over=%b required 0/0", bus.leds, bus.game_over);
        end
    endtask

    task automatic test_double_press();
        int it;
        logic [N-1:0] other;
        bus.en = 1'b1;
        exp_score = '0; exp_lives = 3'(LIV);
        wait_mole(it);
        other = {bus.leds[N-2:0], bus.leds[N-1]};
        press_hit(other, 1'b0);
        wait_mole(it);
        // Run the mole down to its last tick, then hit on the expiring tick.
        for (int i = 0; i < MOLE - 1; i++) begin
            bus.tick = 1'b1;
            @(negedge clk);
        end
        bus.tick = 1'b0;
        n_checks++;
        if (bus.miss !== 1'b0 || bus.leds === '0) begin
            n_fail++; $display("FAIL early_timeout: miss=%b leds=%h required 0/nonzero", bus.miss, bus.leds);
        end
        press_hit('0, 1'b1);
    endtask

    task automatic test_wrong_press_and_abort();
        int it;
        exp_t e;
        wait_mole(it);
        exp_lives = exp_lives - 3'd1;
        sb.push_back('{exp_score, exp_lives});
        bus.button = {bus.leds[N-2:0], bus.leds[N-1]};
        @(negedge clk);
        bus.button = '0;
        e = sb.pop_front();
        $display("wrong: hit=%b miss=%b lives=%0d leds=%h", bus.hit, bus.miss, bus.lives, bus.leds);
        n_checks++;
        if (bus.miss !== 1'b1 || bus.hit !== 1'b0) begin
            n_fail++; $display("FAIL wrong_pulse: hit/miss=%b%b required 01", bus.hit, bus.miss);
        end
        n_checks++;
        if (bus.lives !== e.lives || bus.leds !== '0) begin
            n_fail++; $display("FAIL wrong_state: lives=%0d leds=%h required %0d/0", bus.lives, bus.leds, e.lives);
        end
        wait_mole(it);
        bus.en = 1'b0;
        @(negedge clk);
        $display("abort: leds=%h miss=%b score=%0d", bus.leds, bus.miss, bus.score);
        n_checks++;
        if (bus.leds !== '0 || bus.miss !== 1'b0 || bus.score !== exp_score || bus.lives !== exp_lives) begin
            n_fail++;
            $display("FAIL abort: leds=%h miss=%b score=%0d lives=%0d required 0/0/%0d/%0d",
                     bus.leds, bus.miss, bus.score, bus.lives, exp_score, exp_lives);
        end
    endtask

    task automatic test_level();
        int it, nt;
        @(negedge clk);
        bus.en = 1'b1;
        exp_score = '0; exp_lives = 3'(LIV);
        for (int i = 0; i < STEP; i++) begin
            wait_mole(it);
            press_hit('0, 1'b0);
        end
        wait_mole(it);
        time_out(nt);
        n_checks++;
        if (nt !== MOLE - 1) begin n_fail++; $display("FAIL level1_lifetime: %0d ticks required %0d", nt, MOLE - 1); end
        for (int i = STEP; i < 7 * STEP; i++) begin
            wait_mole(it);
            press_hit('0, 1'b0);
        end
        wait_mole(it);
        time_out(nt);
        n_checks++;
        if (nt !== MINT) begin n_fail++; $display("FAIL floor_lifetime: %0d ticks required %0d", nt, MINT); end
    endtask

    task automatic test_score_saturation();
        int it;
        for (int i = 0; i < 7; i++) begin
            wait_mole(it);
            press_hit('0, 1'b0);
        end
        n_checks++;
        if (bus.score !== SW'(SMAX)) begin n_fail++; $display("FAIL score_sat: score=%0d required %0d", bus.score, SMAX); end
    endtask

    task automatic test_back_to_back();
        int it, start;
        start = spawns;
        for (int i = 0; i < 1000; i++) begin
            wait_mole(it);
            press_hit('0, 1'b0);
        end
        n_checks++;
        if (spawns - start !== 1000) begin n_fail++; $display("FAIL spawn_count: %0d required 1000", spawns - start); end
    endtask

    task automatic test_async_reset();
        int it;
        wait_mole(it);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: leds=%h score=%0d lives=%0d", bus.leds, bus.score, bus.lives);
        n_checks++;
        if (bus.leds !== '0 || bus.score !== '0 || bus.lives !== 3'(LIV) || bus.game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: leds=%h score=%0d lives=%0d over=%b required 0/0/%0d/0",
                     bus.leds, bus.score, bus.lives, bus.game_over, LIV);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_prev = 0; last_mole = '0; exp_score = '0; exp_lives = 3'(LIV);
        wait_mole(it);
        n_checks++;
        if (it !== 2) begin n_fail++; $display("FAIL restart_latency: %0d cycles required 2", it); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_timeout_to_over();
        test_double_press();
        test_wrong_press_and_abort();
        test_level();
        test_score_saturation();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
